// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared FSM encoding, default widths and opcodes for the ALU front end
package alu_pkg;

    localparam int ALU_WIDTH = 8;
    localparam int ALU_OPW   = 3;

    typedef enum logic [1:0] {
        S_OP    = 2'd0,
        S_A     = 2'd1,
        S_B     = 2'd2,
        S_ISSUE = 2'd3
    } loader_state_t;

    // Opcode values are passed through untouched; the ALU owns their meaning.
    localparam logic [ALU_OPW-1:0] OP_ADD = 3'd0;
    localparam logic [ALU_OPW-1:0] OP_SUB = 3'd1;
    localparam logic [ALU_OPW-1:0] OP_AND = 3'd2;
    localparam logic [ALU_OPW-1:0] OP_OR  = 3'd3;
    localparam logic [ALU_OPW-1:0] OP_XOR = 3'd4;
    localparam logic [ALU_OPW-1:0] OP_SHL = 3'd5;
    localparam logic [ALU_OPW-1:0] OP_SHR = 3'd6;
    localparam logic [ALU_OPW-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - serial opcode/A/B word stream to parallel ALU bundle
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OPW-1:0]   out_op,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [7:0]       txn_count
);

    loader_state_t    r_state;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_out_valid;
    logic [7:0]       r_txn_count;
    logic             w_in_ready;
    logic             w_accept;

    assign w_in_ready = rst_n && (r_state != S_ISSUE);
    assign w_accept   = in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_OP;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_out_valid <= 1'b0;
            r_txn_count <= 8'd0;
        end else if (flush) begin
            // Abort wins over both handshakes; captured data is left as-is.
            r_state     <= S_OP;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_OP: begin
                    if (w_accept) begin
                        r_op    <= in_data[OPW-1:0];
                        r_state <= S_A;
                    end
                end
                S_A: begin
                    if (w_accept) begin
                        r_a     <= in_data;
                        r_state <= S_B;
                    end
                end
                S_B: begin
                    if (w_accept) begin
                        r_b         <= in_data;
                        r_state     <= S_ISSUE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (out_ready) begin
                        r_state     <= S_OP;
                        r_out_valid <= 1'b0;
                        r_txn_count <= r_txn_count + 8'd1;
                    end
                end
                default: begin
                    r_state     <= S_OP;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_op    = r_op;
    assign out_a     = r_a;
    assign out_b     = r_b;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == S_A) || (r_state == S_B);
    assign txn_count = r_txn_count;

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - directed plus randomized check of alu_operand_loader against a word-queue model
module tb_alu_operand_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] out_op;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic [7:0] txn_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_words[$];
    logic [2:0] m_op;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [7:0] m_cnt;

    alu_operand_loader #(.WIDTH(8), .OPW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_op    (out_op),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: an operation is just the list of words accepted since the last
    // reset/flush/transfer; three words means a bundle is on offer.
    task automatic model_edge(input logic rn, input logic fl, input logic iv,
                              input logic [7:0] d, input logic ordy);
        if (!rn) begin
            m_words.delete();
            m_op = 3'd0; m_a = 8'd0; m_b = 8'd0; m_cnt = 8'd0;
        end else if (fl) begin
            m_words.delete();
        end else if (m_words.size() == 3) begin
            if (ordy) begin
                m_words.delete();
                m_cnt = m_cnt + 8'd1;
            end
        end else if (iv) begin
            case (m_words.size())
                0: m_op = d[2:0];
                1: m_a  = d;
                default: m_b = d;
            endcase
            m_words.push_back(d);
        end
    endtask

    task automatic step(input logic rn, input logic fl, input logic iv,
                        input logic [7:0] d, input logic ordy);
        rst_n = rn; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge clk);
        model_edge(rn, fl, iv, d, ordy);
        #1;
        chk("in_ready",  32'(in_ready),  32'(rn && (m_words.size() != 3)));
        chk("out_valid", 32'(out_valid), 32'(m_words.size() == 3));
        chk("busy",      32'(busy),      32'((m_words.size() == 1) || (m_words.size() == 2)));
        chk("txn_count", 32'(txn_count), 32'(m_cnt));
        chk("out_op",    32'(out_op),    32'(m_op));
        chk("out_a",     32'(out_a),     32'(m_a));
        chk("out_b",     32'(out_b),     32'(m_b));
    endtask

    initial begin
        logic [7:0] w0, w1, w2;
        m_op = 3'd0; m_a = 8'd0; m_b = 8'd0; m_cnt = 8'd0;

        // Reset state
        step(1'b0, 1'b0, 1'b1, 8'hAB, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_txn", 32'(txn_count), 32'd0);

        // 1: continuous stream, ALU always ready
        step(1'b1, 1'b0, 1'b1, 8'h02, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'h35, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'h1A, 1'b1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_ready", 32'(in_ready), 32'd0);
        chk("t1_op", 32'(out_op), 32'd2);
        chk("t1_a", 32'(out_a), 32'h35);
        chk("t1_b", 32'(out_b), 32'h1A);
        step(1'b1, 1'b0, 1'b1, 8'h99, 1'b1);
        chk("t1_drop", 32'(out_valid), 32'd0);
        chk("t1_txn", 32'(txn_count), 32'd1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // 2: back-pressure for 5 cycles
        step(1'b1, 1'b0, 1'b1, 8'h02, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h35, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h1A, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h77, 1'b0);
            chk("t2_hold_valid", 32'(out_valid), 32'd1);
            chk("t2_hold_a", 32'(out_a), 32'h35);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("t2_txn", 32'(txn_count), 32'd2);

        // 3: gaps, opcode upper bits dropped
        step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
        chk("t3_busy", 32'(busy), 32'd1);
        step(1'b1, 1'b0, 1'b0, 8'h11, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h22, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'h80, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h33, 1'b0);
        chk("t3_busy_mid", 32'(busy), 32'd1);
        step(1'b1, 1'b0, 1'b1, 8'h7F, 1'b0);
        chk("t3_op", 32'(out_op), 32'd7);
        chk("t3_a", 32'(out_a), 32'h80);
        chk("t3_b", 32'(out_b), 32'h7F);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // 4: flush in S_B, with a word offered in the flush cycle
        step(1'b1, 1'b0, 1'b1, 8'h01, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'h10, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'hEE, 1'b1);
        chk("t4_flush_valid", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, 1'b1, 8'h04, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'hAA, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
        chk("t4_op", 32'(out_op), 32'd4);
        chk("t4_a", 32'(out_a), 32'hAA);
        chk("t4_b", 32'(out_b), 32'h55);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("t4_txn", 32'(txn_count), 32'd4);

        // 5: reset while issuing with out_ready=1
        step(1'b1, 1'b0, 1'b1, 8'h06, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h12, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h34, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h56, 1'b1);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_txn", 32'(txn_count), 32'd0);
        step(1'b1, 1'b0, 1'b1, 8'h03, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'hC3, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'h3C, 1'b1);
        chk("t5_fresh_op", 32'(out_op), 32'd3);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // 6: 256 back-to-back operations from a fresh reset, 4-cycle spacing
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int n = 0; n < 256; n++) begin
            w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
            step(1'b1, 1'b0, 1'b1, w0, 1'b1);
            chk("t6_gap1", 32'(out_valid), 32'd0);
            step(1'b1, 1'b0, 1'b1, w1, 1'b1);
            chk("t6_gap2", 32'(out_valid), 32'd0);
            step(1'b1, 1'b0, 1'b1, w2, 1'b1);
            chk("t6_pulse", 32'(out_valid), 32'd1);
            chk("t6_bundle", {13'd0, out_op, out_a, out_b}, {13'd0, w0[2:0], w1, w2});
            step(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b1);
        end
        chk("t6_wrap", 32'(txn_count), 32'd0);

        // Random soak
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 31) == 0),
                 1'($urandom), 8'($urandom), ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
